// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GNT_CPU,
    ST_GNT_DMA,
    ST_RD_CPU,
    ST_RD_DMA
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [1:0] REGION_RAM  = 2'b00;
  localparam logic [1:0] REGION_LEDS = 2'b01;

  // Wide enough for the largest legal burst limit (15).
  localparam int BURST_W = 4;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Region decode of the granted bus address: top two bits select RAM, LEDS or unmapped.
module mem_addr_decode
  import mem_arb_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [AW-1:0] addr,
  output logic          ram_sel,
  output logic          leds_sel,
  output logic          err_sel
);

  logic [1:0] region;

  always_comb begin
    region   = addr[AW-1 -: 2];
    ram_sel  = (region == REGION_RAM);
    leds_sel = (region == REGION_LEDS);
    err_sel  = region[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the 9-bit memory-mapped bus (128x9 RAM + LEDS register).
// Build option: define ARB_RR_EN for round-robin tie-break; otherwise fixed CPU > DMA priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 9,
  parameter int DW        = 9,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [6:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          leds_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

  arb_state_t         state_q, state_d, arb_next;
  owner_t             owner_q, owner_d, acc_owner, winner;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               rd_ram_q, rd_ram_d;

  logic               in_gnt, sel_dma, sel_req, sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic               access, other_req, idle_other_req;
  logic               ram_sel, leds_sel, err_sel;

  // Bus mux: the port named by the grant state drives the shared bus; a dropped req
  // in its grant cycle means the access is withdrawn.
  always_comb begin
    sel_dma   = (state_q == ST_GNT_DMA);
    in_gnt    = (state_q == ST_GNT_CPU) || (state_q == ST_GNT_DMA);
    sel_req   = sel_dma ? dma_req   : cpu_req;
    sel_we    = sel_dma ? dma_we    : cpu_we;
    sel_addr  = sel_dma ? dma_addr  : cpu_addr;
    sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
    access    = in_gnt && sel_req;
    acc_owner = sel_dma ? OWN_DMA : OWN_CPU;
  end

  mem_addr_decode #(
    .AW (AW)
  ) u_decode (
    .addr     (sel_addr),
    .ram_sel  (ram_sel),
    .leds_sel (leds_sel),
    .err_sel  (err_sel)
  );

  always_comb begin
    cpu_gnt    = access && !sel_dma;
    dma_gnt    = access && sel_dma;
    mem_addr   = access ? sel_addr[6:0] : 7'd0;
    mem_wdata  = access ? sel_wdata : '0;
    mem_wren   = access && sel_we && ram_sel;
    leds_en    = access && sel_we && leds_sel;
    bus_err    = access && err_sel;
    cpu_rvalid = (state_q == ST_RD_CPU);
    dma_rvalid = (state_q == ST_RD_DMA);
    cpu_rdata  = (cpu_rvalid && rd_ram_q) ? mem_rdata : '0;
    dma_rdata  = (dma_rvalid && rd_ram_q) ? mem_rdata : '0;
  end

  // Burst tracking includes this cycle's grant so the arbitration below already sees it.
  always_comb begin
    owner_d        = owner_q;
    burst_d        = burst_q;
    other_req      = sel_dma ? cpu_req : dma_req;
    idle_other_req = (owner_q == OWN_CPU) ? dma_req : cpu_req;
    if (access) begin
      owner_d = acc_owner;
      if (!other_req) begin
        burst_d = '0;
      end else if (acc_owner != owner_q) begin
        burst_d = BURST_W'(1);
      end else if (burst_q != '1) begin
        burst_d = burst_q + BURST_W'(1);
      end
    end else if (!idle_other_req) begin
      burst_d = '0;
    end
  end

  always_comb begin
    winner = OWN_CPU;
    if (cpu_req && dma_req) begin
      if (burst_d >= BURST_LIM) begin
        winner = other_owner(owner_d);
      end else begin
`ifdef ARB_RR_EN
        winner = other_owner(owner_d);
`else
        winner = OWN_CPU;
`endif
      end
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
    if (!cpu_req && !dma_req) begin
      arb_next = ST_IDLE;
    end else begin
      arb_next = (winner == OWN_DMA) ? ST_GNT_DMA : ST_GNT_CPU;
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    rd_ram_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_RD_CPU, ST_RD_DMA: begin
        state_d = arb_next;
      end
      ST_GNT_CPU, ST_GNT_DMA: begin
        if (access && !sel_we) begin
          state_d  = sel_dma ? ST_RD_DMA : ST_RD_CPU;
          rd_ram_d = ram_sel;
        end else begin
          state_d = arb_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CPU;
      burst_q  <= '0;
      rd_ram_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      rd_ram_q <= rd_ram_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter with a per-cycle transaction model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [8:0] cpu_addr = '0, cpu_wdata = '0;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [8:0] dma_addr = '0, dma_wdata = '0;
  logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [8:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [6:0] mem_addr;
  logic       mem_wren, leds_en, bus_err;
  logic [8:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(9), .DW(9), .MAX_BURST(MAXB)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .leds_en(leds_en),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // Synchronous 128x9 RAM attached to the arbiter's memory side.
  logic [8:0] ram [128] = '{default: '0};
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wren) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
                mem_addr, mem_wdata, mem_wren, leds_en, bus_err});
  endfunction

  // ---------------- reference model (ports: 0 none, 1 CPU, 2 DMA) ----------------
  int         slot = 0;
  int         own = 1;
  int         hist[$];
  int         rd_port = 0;
  logic [8:0] rd_val = '0;
  logic [8:0] m_mem [128] = '{default: '0};
  bit         cpu_gs = 1'b0, dma_gs = 1'b0;
  int         gp;
  bit         oreq, e_we;
  logic [8:0] e_addr, e_wdata;
  logic       e_wren, e_leds, e_err;

  function automatic int other_port(input int p);
    return (p == 1) ? 2 : 1;
  endfunction

  function automatic int pick(input bit c, input bit d);
    if (c && d) begin
      if (hist.size() >= MAXB) return other_port(own);
`ifdef ARB_RR_EN
      return other_port(own);
`else
      return 1;
`endif
    end
    if (c) return 1;
    if (d) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_outputs_zero", all_outs(), 64'd0);
      slot = 0; own = 1; hist.delete(); rd_port = 0; rd_val = '0;
      cpu_gs = 1'b0; dma_gs = 1'b0;
    end else begin
      gp = 0;
      if (slot == 1 && cpu_req) gp = 1;
      if (slot == 2 && dma_req) gp = 2;
      e_we    = (gp == 2) ? dma_we    : cpu_we;
      e_addr  = (gp == 2) ? dma_addr  : cpu_addr;
      e_wdata = (gp == 2) ? dma_wdata : cpu_wdata;
      e_wren  = (gp != 0) && e_we && (e_addr[8:7] == 2'b00);
      e_leds  = (gp != 0) && e_we && (e_addr[8:7] == 2'b01);
      e_err   = (gp != 0) && e_addr[8];
      chk("cpu_gnt", 64'(cpu_gnt), 64'(gp == 1));
      chk("dma_gnt", 64'(dma_gnt), 64'(gp == 2));
      chk("mem_addr", 64'(mem_addr), (gp != 0) ? 64'(e_addr[6:0]) : 64'd0);
      chk("mem_wdata", 64'(mem_wdata), (gp != 0) ? 64'(e_wdata) : 64'd0);
      chk("mem_wren", 64'(mem_wren), 64'(e_wren));
      chk("leds_en", 64'(leds_en), 64'(e_leds));
      chk("bus_err", 64'(bus_err), 64'(e_err));
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(rd_port == 1));
      chk("cpu_rdata", 64'(cpu_rdata), (rd_port == 1) ? 64'(rd_val) : 64'd0);
      chk("dma_rvalid", 64'(dma_rvalid), 64'(rd_port == 2));
      chk("dma_rdata", 64'(dma_rdata), (rd_port == 2) ? 64'(rd_val) : 64'd0);
      chk("one_gnt_max", 64'(cpu_gnt && dma_gnt), 64'd0);
      chk("one_enable_max", 64'(mem_wren && leds_en), 64'd0);
      cpu_gs = (gp == 1);
      dma_gs = (gp == 2);
      if (e_wren) m_mem[e_addr[6:0]] = e_wdata;
      if (gp != 0) begin
        oreq = (gp == 1) ? dma_req : cpu_req;
        if (!oreq) hist.delete();
        else begin
          if (hist.size() > 0 && hist[$] != gp) hist.delete();
          hist.push_back(gp);
        end
        own = gp;
      end else if (!((own == 1) ? dma_req : cpu_req)) begin
        hist.delete();
      end
      rd_port = 0;
      rd_val  = '0;
      if (gp != 0 && !e_we) begin
        rd_port = gp;
        rd_val  = (e_addr[8:7] == 2'b00) ? m_mem[e_addr[6:0]] : 9'h000;
        slot    = 0;
      end else begin
        slot = pick(cpu_req, dma_req);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn(output logic req, output logic we, output logic [8:0] addr,
                         output logic [8:0] wdata);
    int         r;
    logic [1:0] rg;
    req = ($urandom_range(0, 9) < 6);
    we  = 1'($urandom_range(0, 1));
    r   = $urandom_range(0, 9);
    if (r < 7) rg = 2'b00;
    else if (r == 7) rg = 2'b01;
    else rg = 2'(r - 6);
    addr  = {rg, 3'b000, 4'($urandom_range(0, 15))};
    wdata = 9'($urandom);
  endtask

  int exp_seq [10];
  int ci, di;

  initial begin
`ifdef ARB_RR_EN
    exp_seq = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`else
    exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`endif
    cyc(); cyc();
    #2 chk("t0_reset_state", all_outs(), 64'd0);
    cyc(); resetn = 1'b1;
    cyc();

    // CPU write 0x005 <- 0x1A3
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 9'h1A3;
    #2 chk("t1_no_gnt_same_cycle", 64'(cpu_gnt), 64'd0);
    cyc();
    #2 chk("t1_gnt", 64'(cpu_gnt), 64'd1);
    chk("t1_wren", 64'(mem_wren), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h05);
    chk("t1_wdata", 64'(mem_wdata), 64'h1A3);
    chk("t1_leds_en", 64'(leds_en), 64'd0);
    cyc(); cpu_req = 1'b0; cpu_we = 1'b0;
    #2 chk("t1_no_second_access", 64'(cpu_gnt), 64'd0);
    cyc();

    // CPU read 0x005
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    cyc();
    #2 chk("t2_gnt", 64'(cpu_gnt), 64'd1);
    chk("t2_no_wren", 64'(mem_wren), 64'd0);
    chk("t2_addr", 64'(mem_addr), 64'h05);
    cyc(); cpu_req = 1'b0;
    #2 chk("t2_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t2_rdata", 64'(cpu_rdata), 64'h1A3);
    chk("t2_dma_rvalid", 64'(dma_rvalid), 64'd0);
    cyc();

    // DMA write to LEDS, then back-to-back write to unmapped space
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h080; dma_wdata = 9'h0FF;
    cyc();
    #2 chk("t3_leds_gnt", 64'(dma_gnt), 64'd1);
    chk("t3_leds_en", 64'(leds_en), 64'd1);
    chk("t3_leds_no_wren", 64'(mem_wren), 64'd0);
    chk("t3_leds_wdata", 64'(mem_wdata), 64'h0FF);
    cyc(); dma_addr = 9'h100; dma_wdata = 9'h055;
    #2 chk("t3_err_gnt", 64'(dma_gnt), 64'd1);
    chk("t3_bus_err", 64'(bus_err), 64'd1);
    chk("t3_err_enables", 64'({mem_wren, leds_en}), 64'd0);
    cyc(); dma_req = 1'b0; dma_we = 1'b0;
    #2 chk("t3_dma_done", 64'(dma_gnt), 64'd0);
    cyc();

    // Request withdrawn before its grant cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h00A; cpu_wdata = 9'h111;
    cyc(); cpu_req = 1'b0;
    #2 chk("wd_no_gnt", 64'(cpu_gnt), 64'd0);
    chk("wd_no_wren", 64'(mem_wren), 64'd0);
    cyc(); cyc();

    // Both ports request writes continuously
    ci = 0; di = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 9'h100;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h020; dma_wdata = 9'h040;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (cpu_gs) begin ci++; cpu_addr = 9'(16 + ci); cpu_wdata = 9'(256 + ci); end
      if (dma_gs) begin di++; dma_addr = 9'(32 + di); dma_wdata = 9'(64 + di); end
      #2 chk($sformatf("t4_grant_%0d", i), 64'({dma_gnt, cpu_gnt}),
             (exp_seq[i] == 1) ? 64'd1 : 64'd2);
    end
    cyc(); cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cyc(); cyc();

    // Reset asserted during the CPU read-data cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    cyc();
    #2 chk("t5_gnt", 64'(cpu_gnt), 64'd1);
    cyc(); cpu_req = 1'b0;
    #2 chk("t5_rvalid_before_reset", 64'(cpu_rvalid), 64'd1);
    chk("t5_rdata_before_reset", 64'(cpu_rdata), 64'h100);
    resetn = 1'b0;
    #1 chk("t5_rvalid_dropped", 64'(cpu_rvalid), 64'd0);
    chk("t5_outputs_zero", all_outs(), 64'd0);
    cyc(); cyc();
    resetn = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h030; cpu_wdata = 9'h0AA;
    #2 chk("t5_no_gnt_at_release", 64'(cpu_gnt), 64'd0);
    cyc();
    #2 chk("t5_first_gnt", 64'(cpu_gnt), 64'd1);
    chk("t5_first_addr", 64'(mem_addr), 64'h30);
    cyc(); cpu_req = 1'b0; cpu_we = 1'b0;
    cyc(); cyc();

    // Randomized traffic on both ports, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (cpu_gs || !cpu_req) new_txn(cpu_req, cpu_we, cpu_addr, cpu_wdata);
      else if ($urandom_range(0, 19) == 0) cpu_req = 1'b0;
      if (dma_gs || !dma_req) new_txn(dma_req, dma_we, dma_addr, dma_wdata);
      else if ($urandom_range(0, 19) == 0) dma_req = 1'b0;
    end
    cyc(); cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
